// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: one signed MAC walks TAPS programmable coefficients per sample,
// then the sum is rounded, shifted and saturated into a valid/ready output register.
module fir_mac_filter #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 20,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0,
    parameter int AW     = $clog2(TAPS),
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     busy
);

    localparam int PW     = DATA_W + COEF_W;
    localparam int RW     = ACC_W + 1;
    localparam int EW     = ((RW > OUT_W) ? RW : OUT_W) + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [AW-1:0]         LAST_K = AW'(TAPS - 1);
    localparam logic [AW:0]           TAPS_E = (AW + 1)'(TAPS);
    localparam logic signed [RW-1:0]  RND    = (SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RND_SH)
                                                           : {RW{1'b0}};
    localparam logic signed [EW-1:0]  MAX_E  = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0]  MIN_E  = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    state_r, state_n;
    logic signed [DATA_W-1:0]  x_r [0:TAPS-1];
    logic signed [COEF_W-1:0]  c_r [0:TAPS-1];
    logic signed [ACC_W-1:0]   acc_r;
    logic [AW-1:0]             k_r;
    logic                      out_valid_r;
    logic signed [OUT_W-1:0]   out_data_r;
    logic                      out_sat_r;
    logic                      in_ready_r;
    logic                      busy_r;
    logic                      accept_s;
    logic                      coef_wr_s;
    logic signed [PW-1:0]      xe_s, ce_s, prod_s;
    logic [OUT_W:0]            res_s;

    // Round half up, arithmetic shift, then clamp; returns {sat, data}.
    function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] w;
        logic signed [RW-1:0] t;
        logic signed [EW-1:0] e;
        w = {a[ACC_W-1], a};
        if (SHIFT > 0) begin
            t = (w + RND) >>> SHIFT;
        end else begin
            t = w;
        end
        e = {{(EW-RW){t[RW-1]}}, t};
        if (e > MAX_E) begin
            round_sat = {1'b1, MAX_E[OUT_W-1:0]};
        end else if (e < MIN_E) begin
            round_sat = {1'b1, MIN_E[OUT_W-1:0]};
        end else begin
            round_sat = {1'b0, e[OUT_W-1:0]};
        end
    endfunction

    // Next-state and handshake strobes
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        coef_wr_s = 1'b0;
        case (state_r)
            IDLE: begin
                coef_wr_s = coef_we && ({1'b0, coef_addr} < TAPS_E);
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_n  = MAC;
                end else begin
                    state_n  = IDLE;
                end
            end
            MAC: begin
                if (k_r == LAST_K) begin
                    state_n = OUT;
                end else begin
                    state_n = MAC;
                end
            end
            OUT: begin
                if (out_valid_r && out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = OUT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Current tap product, sign-extended to full product width before multiplying
    always_comb begin
        xe_s   = {{COEF_W{x_r[k_r][DATA_W-1]}}, x_r[k_r]};
        ce_s   = {{DATA_W{c_r[k_r][COEF_W-1]}}, c_r[k_r]};
        prod_s = xe_s * ce_s;
        res_s  = round_sat(acc_r);
    end

    // State register and registered status outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            in_ready_r <= (state_n == IDLE);
            busy_r     <= (state_n != IDLE);
        end
    end

    // Coefficient bank, delay line, accumulator and output register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_r[i] <= {DATA_W{1'b0}};
                c_r[i] <= {COEF_W{1'b0}};
            end
            acc_r       <= {ACC_W{1'b0}};
            k_r         <= {AW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_sat_r   <= 1'b0;
        end else begin
            if (coef_wr_s) begin
                c_r[coef_addr] <= coef_wdata;
            end
            if (accept_s) begin
                x_r[0] <= in_data;
                for (int i = 1; i < TAPS; i++) begin
                    x_r[i] <= x_r[i-1];
                end
                acc_r <= {ACC_W{1'b0}};
                k_r   <= {AW{1'b0}};
            end
            if (state_r == MAC) begin
                acc_r <= acc_r + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
                if (k_r != LAST_K) begin
                    k_r <= k_r + AW'(1'b1);
                end
            end
            // OUT spends its first cycle loading the result, then holds until taken
            if (state_r == OUT) begin
                if (!out_valid_r) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= res_s[OUT_W-1:0];
                    out_sat_r   <= res_s[OUT_W];
                end else if (out_ready) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

endmodule
